// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program counter and fetch control with a start/done run
//               handshake, label lookup hand-off and a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int PC_W      = 12,
    parameter int LABEL_W   = 8,
    parameter int START_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           halt,
    input  logic                           br_en,
    input  logic                           br_uncond,
    input  logic                           flag,
    input  logic                           call,
    input  logic                           ret,
    input  logic [LABEL_W-1:0]             label,
    input  logic [PC_W-1:0]                lut_next_pc,
    output logic [LABEL_W-1:0]             lut_label,
    output logic [PC_W-1:0]                pc,
    output logic                           running,
    output logic                           done,
    output logic                           ras_err,
    output logic [$clog2(RAS_DEPTH):0]     ras_depth
);

    localparam int c_IDX_W   = $clog2(RAS_DEPTH);
    localparam int c_DEPTH_W = c_IDX_W + 1;
    localparam logic [PC_W-1:0]      c_START = PC_W'(START_PC);
    localparam logic [c_DEPTH_W-1:0] c_FULL  = c_DEPTH_W'(RAS_DEPTH);
    localparam logic [c_DEPTH_W-1:0] c_ONE   = c_DEPTH_W'(1);
    localparam logic [PC_W-1:0]      c_PC_ONE = PC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PC_W-1:0]        r_pc;
    logic                   r_running;
    logic                   r_done;
    logic                   r_err;
    logic [c_DEPTH_W-1:0]   r_depth;
    logic [PC_W-1:0]        r_ras [RAS_DEPTH];

    logic [PC_W-1:0]        w_pc_inc;
    logic [c_DEPTH_W-1:0]   w_depth_m1;
    logic [PC_W-1:0]        w_top;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_taken;
    logic                   w_active;
    logic                   w_push;

    // Modulo-2^PC_W increment; the same value is what a call pushes.
    assign w_pc_inc   = r_pc + c_PC_ONE;
    assign w_depth_m1 = r_depth - c_ONE;
    assign w_top      = r_ras[w_depth_m1[c_IDX_W-1:0]];
    assign w_full     = (r_depth == c_FULL);
    assign w_empty    = (r_depth == '0);
    assign w_taken    = br_en & (br_uncond | flag);
    assign w_active   = (r_state == ST_RUN) & ~reset & ~stall;
    assign w_push     = w_active & ~halt & call & ~w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= c_START;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_depth   <= '0;
            r_err     <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_pc      <= c_START;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                        r_depth   <= '0;
                        r_err     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state   <= ST_HALT;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (call) begin
                        // A call on a full stack still jumps; only the push is lost.
                        if (!w_full) begin
                            r_depth <= r_depth + c_ONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_pc <= lut_next_pc;
                    end else if (ret) begin
                        if (!w_empty) begin
                            r_pc    <= w_top;
                            r_depth <= w_depth_m1;
                        end else begin
                            r_err <= 1'b1;
                            r_pc  <= w_pc_inc;
                        end
                    end else if (w_taken) begin
                        r_pc <= lut_next_pc;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Stack storage needs no reset: only entries below r_depth are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_depth[c_IDX_W-1:0]] <= w_pc_inc;
        end
    end

    assign lut_label = label;
    assign pc        = r_pc;
    assign running   = r_running;
    assign done      = r_done;
    assign ras_err   = r_err;
    assign ras_depth = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Self-checking bench for pc_fetch_ctrl with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int PC_W = 12;
    localparam int LABEL_W = 8;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MOD = 4096;

    logic clk, reset, start, stall, halt, br_en, br_uncond, flag, call, ret;
    logic [LABEL_W-1:0] label;
    logic [PC_W-1:0] lut_next_pc;
    logic [LABEL_W-1:0] lut_label;
    logic [PC_W-1:0] pc;
    logic running, done, ras_err;
    logic [2:0] ras_depth;

    int n_checks = 0;
    int n_fail = 0;

    pc_fetch_ctrl #(.PC_W(PC_W), .LABEL_W(LABEL_W), .START_PC(0), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .br_en(br_en), .br_uncond(br_uncond), .flag(flag), .call(call), .ret(ret),
        .label(label), .lut_next_pc(lut_next_pc), .lut_label(lut_label), .pc(pc),
        .running(running), .done(done), .ras_err(ras_err), .ras_depth(ras_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode is "idle"/"run"/"halt", stack is a queue.
    string m_mode = "idle";
    int    m_pc = 0;
    int    m_stack[$];
    bit    m_err = 0;
    bit    m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = "idle"; m_pc = 0; m_stack.delete(); m_err = 0; m_valid = 1;
        end else if (!stall) begin
            if (m_mode != "run") begin
                if (start) begin
                    m_mode = "run"; m_pc = 0; m_stack.delete(); m_err = 0;
                end
            end else if (halt) begin
                m_mode = "halt";
            end else if (call) begin
                if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) % PC_MOD);
                else m_err = 1;
                m_pc = lut_next_pc;
            end else if (ret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin m_err = 1; m_pc = (m_pc + 1) % PC_MOD; end
            end else if (br_en && (br_uncond || flag)) begin
                m_pc = lut_next_pc;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", int'(pc), m_pc);
            chk("model_running", int'(running), int'(m_mode == "run"));
            chk("model_done", int'(done), int'(m_mode == "halt"));
            chk("model_depth", int'(ras_depth), m_stack.size());
            chk("model_err", int'(ras_err), int'(m_err));
            chk("lut_label", int'(lut_label), int'(label));
        end
    end

    // Inputs change 2 time units after the rising edge; checks follow there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_dec();
        start = 0; stall = 0; halt = 0; br_en = 0; br_uncond = 0; flag = 0;
        call = 0; ret = 0; label = '0; lut_next_pc = '0;
    endtask

    task automatic jump(input int tgt);
        br_en = 1; br_uncond = 1; label = 8'h11; lut_next_pc = PC_W'(tgt);
        tick();
        clear_dec();
    endtask

    initial begin
        clear_dec();
        reset = 1;
        tick(); tick();
        reset = 0;
        // 1: reset state, start, sequential run
        chk("rst_pc", int'(pc), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_depth", int'(ras_depth), 0);
        chk("rst_err", int'(ras_err), 0);
        start = 1; tick(); start = 0;
        chk("start_pc", int'(pc), 0);
        chk("start_running", int'(running), 1);
        for (int i = 0; i < 20; i++) tick();
        chk("seq20_pc", int'(pc), 20);
        chk("seq20_done", int'(done), 0);
        // 2: conditional branch taken / not taken
        jump(5);
        chk("at5", int'(pc), 5);
        br_en = 1; flag = 1; label = 3; lut_next_pc = 208; tick(); clear_dec();
        chk("br_taken", int'(pc), 208);
        jump(5);
        br_en = 1; flag = 0; label = 3; lut_next_pc = 208; tick(); clear_dec();
        chk("br_not_taken", int'(pc), 6);
        // 3: two calls, two returns
        jump(10);
        call = 1; lut_next_pc = 352; tick(); clear_dec();
        chk("call1_pc", int'(pc), 352); chk("call1_depth", int'(ras_depth), 1);
        tick();
        chk("seq_353", int'(pc), 353);
        call = 1; lut_next_pc = 8; tick(); clear_dec();
        chk("call2_pc", int'(pc), 8); chk("call2_depth", int'(ras_depth), 2);
        ret = 1; tick();
        chk("ret1_pc", int'(pc), 354); chk("ret1_depth", int'(ras_depth), 1);
        tick(); clear_dec();
        chk("ret2_pc", int'(pc), 11); chk("ret2_depth", int'(ras_depth), 0);
        chk("ret2_err", int'(ras_err), 0);
        // 4: overflow then underflow
        for (int i = 1; i <= 5; i++) begin
            call = 1; lut_next_pc = PC_W'(100 * i); tick();
        end
        clear_dec();
        chk("ovf_pc", int'(pc), 500); chk("ovf_depth", int'(ras_depth), 4);
        chk("ovf_err", int'(ras_err), 1);
        ret = 1;
        tick(); chk("pop1", int'(pc), 301);
        tick(); chk("pop2", int'(pc), 201);
        tick(); chk("pop3", int'(pc), 101);
        tick(); chk("pop4", int'(pc), 12);
        tick(); clear_dec();
        chk("udf_pc", int'(pc), 13); chk("udf_err", int'(ras_err), 1);
        chk("udf_depth", int'(ras_depth), 0);
        // 5: stall with halt/branch, then halt, then restart
        stall = 1; halt = 1; br_en = 1; br_uncond = 1; lut_next_pc = 77;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_pc", int'(pc), 13); chk("stall_running", int'(running), 1);
        stall = 0; br_en = 0; tick();
        chk("halt_done", int'(done), 1); chk("halt_pc", int'(pc), 13);
        chk("halt_running", int'(running), 0);
        clear_dec(); br_en = 1; br_uncond = 1; lut_next_pc = 99; tick(); clear_dec();
        chk("halt_hold_pc", int'(pc), 13);
        start = 1; tick(); start = 0;
        chk("restart_pc", int'(pc), 0); chk("restart_running", int'(running), 1);
        chk("restart_depth", int'(ras_depth), 0); chk("restart_err", int'(ras_err), 0);
        // 6: wrap, reset mid-run, start in RUN ignored
        jump(4095);
        tick();
        chk("wrap_pc", int'(pc), 0);
        jump(4095);
        call = 1; lut_next_pc = 40; tick(); clear_dec();
        chk("wrap_call_depth", int'(ras_depth), 1);
        ret = 1; tick(); clear_dec();
        chk("wrap_ret_pc", int'(pc), 0);
        call = 1; lut_next_pc = 40; tick();
        reset = 1; lut_next_pc = 77; tick(); reset = 0; clear_dec();
        chk("mid_rst_pc", int'(pc), 0); chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_depth", int'(ras_depth), 0);
        tick();
        chk("idle_hold_pc", int'(pc), 0);
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        start = 1; tick(); start = 0;
        chk("start_in_run_pc", int'(pc), 4); chk("start_in_run_running", int'(running), 1);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage that consumes the label-to-target lookup table. Per cycle it supplies the current instruction address to instruction memory and drives the branch label into the lookup. It takes the combinational target back and selects the next PC from sequential, taken-branch, call or return sources. It also owns the start/done run handshake with the testbench and a small return-address stack.

Parameters:
PC_W, 12, width of program counter and lookup target
LABEL_W, 8, width of branch label
START_PC, 0, PC loaded on reset and on every accepted start
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin program; honoured in IDLE and HALT only
stall  in  1  freeze PC, stack and FSM for this cycle
halt  in  1  decoded halt instruction at current PC
br_en  in  1  decoded branch instruction
br_uncond  in  1  branch ignores flag when set
flag  in  1  ALU condition flag
call  in  1  decoded call (jump to label, push return)
ret  in  1  decoded return (pop)
label  in  LABEL_W  label field of current instruction
lut_next_pc  in  PC_W  target returned by lookup for lut_label
lut_label  out  LABEL_W  label to lookup; combinational copy of label
pc  out  PC_W  current instruction address (registered)
running  out  1  high in RUN
done  out  1  high in HALT
ras_err  out  1  sticky stack overflow/underflow flag
ras_depth  out  clog2(RAS_DEPTH)+1  current stack occupancy

Behaviour:
- Reset (synchronous): state=IDLE, pc=START_PC, running=0, done=0, ras_depth=0, ras_err=0. Reset wins over all inputs. Reset mid-RUN aborts; stack contents are discarded.
- FSM states: IDLE, RUN, HALT.
  - IDLE --start--> RUN, pc<=START_PC.
  - RUN --halt (no stall)--> HALT, pc holds.
  - HALT --start--> RUN, pc<=START_PC, ras_depth<=0, ras_err<=0.
  - start in RUN is ignored.
- running=(state==RUN) and done=(state==HALT); both are registered decodes of state.
- Decode inputs are acted on only in RUN with stall=0. In IDLE and HALT, pc holds and decode inputs are ignored.
- Stall=1 in RUN: pc, stack, ras_err and state all hold. halt under stall is not taken.
- Next-PC priority in RUN when not stalled:
  1. halt: pc holds, go to HALT.
  2. call: if depth<RAS_DEPTH, push pc+1 and depth+1; pc<=lut_next_pc. If full, no push, ras_err<=1, pc<=lut_next_pc.
  3. ret: if depth>0, pc<=top and depth-1. If empty, ras_err<=1, pc<=pc+1.
  4. taken branch, i.e. br_en & (br_uncond | flag): pc<=lut_next_pc.
  5. otherwise: pc<=pc+1.
- PC arithmetic is modulo 2^PC_W, so 4095+1 wraps to 0. A pushed return of pc+1 wraps the same way.
- lut_label=label, combinational, every cycle regardless of state. lut_next_pc is sampled in the same cycle (single-cycle lookup), so branch latency is one cycle with no bubble.
- Return-address stack is LIFO; top is entry depth-1. Only the occupied entries are defined. ras_err is sticky until reset or an accepted start.
- Single-cycle latency from decode inputs to the pc update. There are no multicycle operations.

Test Plan:
1. Reset, then start pulse: pc=0 in the cycle after start. 20 unstalled cycles with no decodes give pc=20. running=1, done=0.
2. At pc=5 assert br_en=1, br_uncond=0, flag=1, label=3, lut_next_pc=208: next pc=208. Repeat with flag=0: next pc=6.
3. Assert call at pc=10 (target 352) and at pc=353 (target 8), then ret twice: pc sequence 352, 8, 354, 11. ras_depth sequence 1, 2, 1, 0. ras_err=0.
4. Five nested calls with RAS_DEPTH=4: fifth call still jumps, ras_err=1, depth=4. Then ret on an empty stack after four pops: pc=pc+1, ras_err stays 1.
5. stall=1 for 3 cycles with halt=1 and br_en=1 asserted: pc and state unchanged. Drop stall with halt=1: done=1 the next cycle, pc frozen. Start in HALT: pc=0, running=1, depth=0, ras_err=0.
6. pc=4095 with no decode: next pc=0. Assert reset mid-RUN with a call pending: next cycle pc=0, IDLE, depth=0. Start asserted while in RUN has no effect.
